// File: rtl/dm_arbiter.sv
// Two-port round-robin data-memory arbiter in front of the MMU. It checks each
// granted access for alignment and address range, and returns one tagged response.
module dm_arbiter (
  input  logic        clk,
  input  logic        resetb,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  input  logic        p0_signed,
  output logic        p0_ack,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  input  logic        p1_signed,
  output logic        p1_ack,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_di,
  output logic [3:0]  dm_be,
  output logic        dm_we,
  output logic        is_signed,
  input  logic [31:0] dm_do,
  input  logic        halt_req,
  output logic        halted,
  output logic [1:0]  fsm_state
);

  // Handshake: pN_ack is high in the cycle pN_req is granted. The requester holds
  // its inputs until then. The response comes back exactly one cycle later.

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state, state_next;

  logic        last_port;
  logic        tag_valid;
  logic        tag_port;
  logic        tag_err;

  logic        grant_en;
  logic        grant;
  logic        sel;
  logic        g_we;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [3:0]  g_be;
  logic        g_signed;
  logic        g_legal;

  function automatic logic is_legal(input logic [31:0] addr, input logic [3:0] be);
    logic align_ok;
    logic range_ok;
    case ({be, addr[1:0]})
      6'b1111_00, 6'b0011_00, 6'b1100_10, 6'b0001_00,
      6'b0010_01, 6'b0100_10, 6'b1000_11: align_ok = 1'b1;
      default:                            align_ok = 1'b0;
    endcase
    range_ok = ((addr >= 32'h1000_0000) && (addr[31] == 1'b0)) ||
               (addr[31:8] == 24'h80_0000);
    return align_ok && range_ok;
  endfunction

  // Grant selection and MMU drive
  always_comb begin
    grant_en = resetb && (state == ST_RUN) && !halt_req;
    sel      = (p0_req && p1_req) ? ~last_port : p1_req;
    grant    = grant_en && (p0_req || p1_req);

    g_we     = sel ? p1_we     : p0_we;
    g_addr   = sel ? p1_addr   : p0_addr;
    g_wdata  = sel ? p1_wdata  : p0_wdata;
    g_be     = sel ? p1_be     : p0_be;
    g_signed = sel ? p1_signed : p0_signed;
    g_legal  = is_legal(g_addr, g_be);

    p0_ack    = grant && !sel;
    p1_ack    = grant && sel;
    dm_addr   = g_addr;
    dm_di     = g_wdata;
    is_signed = g_signed;
    dm_be     = (grant && g_legal) ? g_be : 4'b0000;
    dm_we     = grant && g_legal && g_we;
  end

  // One-entry response tag plus the round-robin pointer
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tag_valid <= 1'b0;
      tag_port  <= 1'b0;
      tag_err   <= 1'b0;
      last_port <= 1'b1;
    end else begin
      tag_valid <= grant;
      if (grant) begin
        tag_port  <= sel;
        tag_err   <= !g_legal;
        last_port <= sel;
      end
    end
  end

  always_comb begin
    p0_rvalid = tag_valid && !tag_port;
    p1_rvalid = tag_valid && tag_port;
    p0_err    = p0_rvalid && tag_err;
    p1_err    = p1_rvalid && tag_err;
    p0_rdata  = (p0_rvalid && !tag_err) ? dm_do : 32'h0;
    p1_rdata  = (p1_rvalid && !tag_err) ? dm_do : 32'h0;
  end

  // Halt FSM
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= ST_RUN;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (halt_req) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!halt_req)      state_next = ST_RUN;
        else if (!tag_valid) state_next = ST_HALTED;
      end
      ST_HALTED: if (!halt_req) state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  assign halted    = (state == ST_HALTED);
  assign fsm_state = state;

endmodule
